// File: rtl/mult_div_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit beside the EX-stage ALU. Executes MULT,
//   MULTU, DIV, DIVU (32 iteration steps plus one fixup cycle) and MTHI/MTLO
//   (single edge), and holds the architectural HI/LO registers.
//
// Optional feature macro: MDU_FAST_MULT_EN
//   When defined, MULT/MULTU use a single-cycle 64-bit multiplier and never
//   raise Busy. Divide always uses the iterative path.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   Start   in   issue strobe, sampled on the rising edge
//   MDCtrl  in   3-bit op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                100 MTHI, 101 MTLO, 110/111 no-op
//   BusA    in   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   BusB    in   rt operand (multiplier / divisor)
//   Busy    out  high while an iterative operation is in flight
//   Done    out  one-cycle pulse when HI/LO first show a new mult/div result
//   HI      out  HI register (remainder or upper product)
//   LO      out  LO register (quotient or lower product)
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MDCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int DW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    ONE_DW = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic             q_neg_q, q_neg_d;  // negate product / quotient in FIX
  logic             r_neg_q, r_neg_d;  // negate remainder in FIX
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operand preparation and iteration datapath
  logic             start_iter;
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [DW-1:0]    div_next;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;
`ifdef MDU_FAST_MULT_EN
  logic [DW-1:0]    fast_mag, fast_prod;
`endif

  // Decode which ops enter the iterative path
  always_comb begin
`ifdef MDU_FAST_MULT_EN
    start_iter = (MDCtrl[2:1] == 2'b01);
`else
    start_iter = (MDCtrl[2] == 1'b0);
`endif
  end

  // Operand magnitudes and sign flags (MDCtrl[0]=0 selects the signed op)
  always_comb begin
    a_neg    = ~MDCtrl[0] & BusA[WIDTH-1];
    b_neg    = ~MDCtrl[0] & BusB[WIDTH-1];
    a_mag    = a_neg ? (~BusA + ONE_W) : BusA;
    b_mag    = b_neg ? (~BusB + ONE_W) : BusB;
    div_zero = (BusB == ZERO_W);
`ifdef MDU_FAST_MULT_EN
    fast_mag  = {ZERO_W, a_mag} * {ZERO_W, b_mag};
    fast_prod = (a_neg ^ b_neg) ? (~fast_mag + ONE_DW) : fast_mag;
`endif
  end

  // One shift-add or restoring-divide step, plus the FIX sign correction
  always_comb begin
    mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO_W});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // A successful subtract always leaves a remainder below the divisor,
    // so the low WIDTH bits of the difference are exact.
    div_sub   = div_shift[WIDTH-1:0] - opnd_q;
    if (div_ge) begin
      div_next = {div_sub, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    prod_fix = q_neg_q ? (~acc_q + ONE_DW) : acc_q;
    if (is_div_q) begin
      fix_lo = q_neg_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
      fix_hi = r_neg_q ? (~acc_q[DW-1:WIDTH] + ONE_W) : acc_q[DW-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[DW-1:WIDTH];
    end
  end

  // State register and all datapath/output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= {DW{1'b0}};
      opnd_q   <= ZERO_W;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= ZERO_W;
      lo_q     <= ZERO_W;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start && start_iter) begin
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDCtrl)
            3'b000, 3'b001: begin
`ifdef MDU_FAST_MULT_EN
              hi_d   = fast_prod[DW-1:WIDTH];
              lo_d   = fast_prod[WIDTH-1:0];
              done_d = 1'b1;
`else
              acc_d    = {ZERO_W, b_mag};
              opnd_d   = a_mag;
              q_neg_d  = a_neg ^ b_neg;
              r_neg_d  = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = 5'd0;
              busy_d   = 1'b1;
`endif
            end
            3'b010, 3'b011: begin
              acc_d    = {ZERO_W, a_mag};
              opnd_d   = b_mag;
              // Divide by zero: the restoring loop yields an all-ones
              // quotient and the dividend as remainder; keeping the quotient
              // unnegated gives LO=all ones, and the remainder sign fix
              // restores HI to the original BusA.
              q_neg_d  = (a_neg ^ b_neg) & ~div_zero;
              r_neg_d  = a_neg;
              is_div_d = 1'b1;
              cnt_d    = 5'd0;
              busy_d   = 1'b1;
            end
            3'b100:  hi_d = BusA;
            3'b101:  lo_d = BusA;
            default: hi_d = hi_q;
          endcase
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          acc_d = div_next;
        end else begin
          acc_d = mul_next;
        end
      end
      S_FIX: begin
        hi_d   = fix_hi;
        lo_d   = fix_lo;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
